slv_guard_rst_seq: RTL and testbench
====================================

// Module: slv_guard_rst_seq
// PURPOSE
// - Downstream of the subordinate guard. Consumes its reset request and sequences recovery of the rogue subordinate.
// - Sequence: isolate, hold subordinate reset, settle, then pulse completion back to the guard's reset-clear input.
// - Escalates to a sticky fatal state when recoveries repeat too often.
// PARAMETERS
// - IsoCycles    8   cycles spent in ISOLATE before asserting subordinate reset (>=1)
// - TmrWidth     8   width of hold/settle programmable counts
// - MaxRetries   3   recoveries allowed inside one quiet window before FATAL
// - QuietCycles  256 cycles in IDLE, with rst_req_i low, that clear the retry count
// - CntWidth     8   width of retry_cnt_o and rst_cnt_o
// PORTS
// - clk_i           in   1         clock
// - rst_i           in   1         synchronous reset, active-high
// - rst_req_i       in   1         level reset request from guard
// - hold_cycles_i   in   TmrWidth  subordinate reset hold length
// - settle_cycles_i in   TmrWidth  post-release settle length
// - fatal_clr_i     in   1         clears FATAL (one-cycle pulse)
// - isolate_o       out  1         gate AXI traffic to/from subordinate
// - sub_rst_no      out  1         subordinate reset, active-low
// - rst_stat_o      out  1         one-cycle completion pulse to guard reset_clear_i
// - busy_o          out  1         state != IDLE
// - fatal_o         out  1         sticky escalation flag
// - retry_cnt_o     out  CntWidth  recoveries in current quiet window
// - rst_cnt_o       out  CntWidth  total recoveries, saturating (macro only)
// BEHAVIOUR
// - One clock (clk_i); reset is synchronous and active-high (rst_i).
// - All outputs registered.
// - On rst_i: state=IDLE, isolate_o=0, sub_rst_no=1, rst_stat_o=0, busy_o=0, fatal_o=0, counters=0.
// - States: IDLE, ISOLATE, ASSERT, SETTLE, DONE, FATAL.
// - IDLE: rst_req_i=1 with retry_cnt_o<MaxRetries -> ISOLATE next cycle; if retry_cnt_o==MaxRetries -> FATAL.
// - ISOLATE: isolate_o=1; stays IsoCycles cycles -> ASSERT.
//   - hold/settle inputs are sampled on the ISOLATE->ASSERT edge.
// - ASSERT: sub_rst_no=0, isolate_o=1; stays max(hold,1) cycles -> SETTLE.
// - SETTLE: sub_rst_no=1, isolate_o=1; stays settle cycles -> DONE.
//   - settle==0: SETTLE lasts 0 cycles and ASSERT goes directly to DONE.
// - DONE: rst_stat_o=1 for exactly one cycle, isolate_o=1; retry_cnt_o++ (saturating) -> IDLE.
// - Latency: rst_req_i rising at IDLE cycle t -> isolate_o=1 at t+1 -> sub_rst_no=0 at t+1+IsoCycles.
// - rst_req_i is ignored outside IDLE. Dropping it mid-sequence does not abort; the sequence completes.
// - rst_req_i still high in IDLE after DONE starts a new sequence (counts as a retry).
// - Quiet timer counts IDLE cycles with rst_req_i=0. At QuietCycles it clears retry_cnt_o; any rst_req_i=1 resets the timer.
// - FATAL: isolate_o=1, sub_rst_no=0, fatal_o=1, rst_stat_o never pulses.
//   - fatal_clr_i -> IDLE with retry_cnt_o=0 and fatal_o=0.
// - rst_i in any state returns to reset values next cycle. No pulse on rst_stat_o.
// CONFIGURATION
// - `SLV_GUARD_RST_CNT_EN defined: rst_cnt_o increments on every DONE and saturates at all-ones; cleared only by rst_i.
// - Macro undefined: rst_cnt_o is tied to '0 and the counter register is not instantiated.
// STRUCTURE
// - Package slv_guard_rst_pkg: state enum rst_state_e, localparams for the state encoding.
// - Sub-module slv_guard_rst_timer: loadable down-counter with zero flag.
//   - Reused for ISOLATE, ASSERT, SETTLE and the quiet window; widths are the max of the needs.
// - Top: FSM, retry/total counters, output registers.
// TESTING
// - Basic: IsoCycles=8, hold=4, settle=2, pulse rst_req_i 1 cycle.
//   - isolate_o high 15 cycles; sub_rst_no low exactly 4; rst_stat_o one pulse at t+15; retry_cnt_o=1.
// - Zero lengths: hold=0, settle=0.
//   - sub_rst_no low 1 cycle; ASSERT->DONE direct; rst_stat_o at t+10.
// - Escalation: 4 back-to-back requests, quiet gap <256.
//   - 4th request enters FATAL; fatal_o=1, sub_rst_no=0, no rst_stat_o; fatal_clr_i -> IDLE, retry_cnt_o=0.
// - Quiet window: 2 recoveries, then 256 idle cycles.
//   - retry_cnt_o=0; the next 3 requests recover without FATAL.
// - Reset mid-operation: rst_i during ASSERT.
//   - next cycle all outputs at reset values; no rst_stat_o pulse; a later request runs a clean sequence.
// - Macro on: 300 recoveries with fatal_clr_i between escalations -> rst_cnt_o saturates at 255. Macro off -> rst_cnt_o==0.

Source files
------------

// File: rtl/slv_guard_rst_pkg.sv
// Shared types for the subordinate reset sequencer: state encoding and a width helper.
package slv_guard_rst_pkg;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StIsolate = 3'd1;
    localparam logic [2:0] StAssert  = 3'd2;
    localparam logic [2:0] StSettle  = 3'd3;
    localparam logic [2:0] StDone    = 3'd4;
    localparam logic [2:0] StFatal   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = StIdle,
        ST_ISOLATE = StIsolate,
        ST_ASSERT  = StAssert,
        ST_SETTLE  = StSettle,
        ST_DONE    = StDone,
        ST_FATAL   = StFatal
    } rst_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/slv_guard_rst_timer.sv
// Loadable down-counter with a zero flag; stops at zero. Shared by every timed phase of the sequencer.
module slv_guard_rst_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);
    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        // NOTE: default assigned first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/slv_guard_rst_seq.sv
// Subordinate reset sequencer: isolate, hold reset, settle, report completion; escalates to sticky FATAL.
// Optional saturating total-recovery counter enabled by `SLV_GUARD_RST_CNT_EN.
module slv_guard_rst_seq
    import slv_guard_rst_pkg::*;
#(
    parameter int unsigned IsoCycles   = 8,
    parameter int unsigned TmrWidth    = 8,
    parameter int unsigned MaxRetries  = 3,
    parameter int unsigned QuietCycles = 256,
    parameter int unsigned CntWidth    = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                rst_req_i,
    input  logic [TmrWidth-1:0] hold_cycles_i,
    input  logic [TmrWidth-1:0] settle_cycles_i,
    input  logic                fatal_clr_i,
    output logic                isolate_o,
    output logic                sub_rst_no,
    output logic                rst_stat_o,
    output logic                busy_o,
    output logic                fatal_o,
    output logic [CntWidth-1:0] retry_cnt_o,
    output logic [CntWidth-1:0] rst_cnt_o
);
    // One counter serves every timed phase, so it is as wide as the largest load value.
    localparam int unsigned TimerW = max_u(TmrWidth, max_u($clog2(IsoCycles), $clog2(QuietCycles)));
    localparam logic [TimerW-1:0]   IsoLoad   = TimerW'(IsoCycles - 1);
    localparam logic [TimerW-1:0]   QuietLoad = TimerW'(QuietCycles - 1);
    localparam logic [TmrWidth-1:0] TmrOne    = TmrWidth'(1);
    localparam logic [CntWidth-1:0] CntOne    = CntWidth'(1);
    localparam logic [CntWidth-1:0] RetryMax  = CntWidth'(MaxRetries);

    rst_state_e          state_d, state_q;
    logic [CntWidth-1:0] retry_cnt_d, retry_cnt_q;
    logic [TmrWidth-1:0] settle_d, settle_q;
    logic                isolate_d, isolate_q;
    logic                sub_rst_n_d, sub_rst_n_q;
    logic                rst_stat_d, rst_stat_q;
    logic                busy_d, busy_q;
    logic                fatal_d, fatal_q;

    logic                tmr_load, tmr_dec, tmr_zero;
    logic [TimerW-1:0]   tmr_load_val;

    slv_guard_rst_timer #(.Width(TimerW)) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        retry_cnt_d  = retry_cnt_q;
        settle_d     = settle_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rst_req_i) begin
                    if (retry_cnt_q >= RetryMax) begin
                        state_d = ST_FATAL;
                    end else begin
                        state_d      = ST_ISOLATE;
                        tmr_load     = 1'b1;
                        tmr_load_val = IsoLoad;
                    end
                end else if (tmr_zero) begin
                    // A full quiet window has elapsed: forgive earlier recoveries.
                    retry_cnt_d  = '0;
                    tmr_load     = 1'b1;
                    tmr_load_val = QuietLoad;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_ISOLATE: begin
                if (tmr_zero) begin
                    state_d      = ST_ASSERT;
                    settle_d     = settle_cycles_i;
                    tmr_load     = 1'b1;
                    tmr_load_val = (hold_cycles_i == '0) ? '0 : TimerW'(hold_cycles_i - TmrOne);
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_ASSERT: begin
                if (tmr_zero) begin
                    if (settle_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d      = ST_SETTLE;
                        tmr_load     = 1'b1;
                        tmr_load_val = TimerW'(settle_q - TmrOne);
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_d = ST_DONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_DONE: begin
                state_d      = ST_IDLE;
                tmr_load     = 1'b1;
                tmr_load_val = QuietLoad;
                if (retry_cnt_q != '1) begin
                    retry_cnt_d = retry_cnt_q + CntOne;
                end
            end
            ST_FATAL: begin
                if (fatal_clr_i) begin
                    state_d      = ST_IDLE;
                    retry_cnt_d  = '0;
                    tmr_load     = 1'b1;
                    tmr_load_val = QuietLoad;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they land in flops aligned with state_q.
    always_comb begin
        isolate_d   = (state_d != ST_IDLE);
        sub_rst_n_d = !((state_d == ST_ASSERT) || (state_d == ST_FATAL));
        rst_stat_d  = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
        fatal_d     = (state_d == ST_FATAL);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            retry_cnt_q <= '0;
            settle_q    <= '0;
            isolate_q   <= 1'b0;
            sub_rst_n_q <= 1'b1;
            rst_stat_q  <= 1'b0;
            busy_q      <= 1'b0;
            fatal_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            retry_cnt_q <= retry_cnt_d;
            settle_q    <= settle_d;
            isolate_q   <= isolate_d;
            sub_rst_n_q <= sub_rst_n_d;
            rst_stat_q  <= rst_stat_d;
            busy_q      <= busy_d;
            fatal_q     <= fatal_d;
        end
    end

    assign isolate_o   = isolate_q;
    assign sub_rst_no  = sub_rst_n_q;
    assign rst_stat_o  = rst_stat_q;
    assign busy_o      = busy_q;
    assign fatal_o     = fatal_q;
    assign retry_cnt_o = retry_cnt_q;

`ifdef SLV_GUARD_RST_CNT_EN
    logic [CntWidth-1:0] rst_cnt_d, rst_cnt_q;

    always_comb begin
        rst_cnt_d = rst_cnt_q;
        if ((state_q == ST_DONE) && (rst_cnt_q != '1)) begin
            rst_cnt_d = rst_cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rst_cnt_q <= '0;
        end else begin
            rst_cnt_q <= rst_cnt_d;
        end
    end

    assign rst_cnt_o = rst_cnt_q;
`else
    assign rst_cnt_o = '0;
`endif

endmodule

// File: tb/tb_slv_guard_rst_seq.sv
// Directed testbench for slv_guard_rst_seq; expected values are hand-derived cycle positions.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_slv_guard_rst_seq;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       rst_req;
    logic [7:0] hold;
    logic [7:0] settle;
    logic       fatal_clr;
    logic       isolate_o, sub_rst_no, rst_stat_o, busy_o, fatal_o;
    logic [7:0] retry_cnt_o, rst_cnt_o;
    logic [4:0] outs;

    int n_vec = 0;
    int n_err = 0;

    // {isolate, sub_rst_n, rst_stat, busy, fatal}
    localparam logic [4:0] OutsIdle  = 5'b01000;
    localparam logic [4:0] OutsFatal = 5'b10011;

`ifdef SLV_GUARD_RST_CNT_EN
    localparam int NumRecov = 300;
    localparam bit CntEn    = 1'b1;
`else
    localparam int NumRecov = 3;
    localparam bit CntEn    = 1'b0;
`endif

    assign outs = {isolate_o, sub_rst_no, rst_stat_o, busy_o, fatal_o};

    slv_guard_rst_seq #(
        .IsoCycles   (8),
        .TmrWidth    (8),
        .MaxRetries  (3),
        .QuietCycles (256),
        .CntWidth    (8)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .rst_req_i       (rst_req),
        .hold_cycles_i   (hold),
        .settle_cycles_i (settle),
        .fatal_clr_i     (fatal_clr),
        .isolate_o       (isolate_o),
        .sub_rst_no      (sub_rst_no),
        .rst_stat_o      (rst_stat_o),
        .busy_o          (busy_o),
        .fatal_o         (fatal_o),
        .retry_cnt_o     (retry_cnt_o),
        .rst_cnt_o       (rst_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_i     = 1'b1;
        rst_req   = 1'b0;
        fatal_clr = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // Pulse rst_req for one cycle, then run len cycles counting completion pulses and FATAL cycles.
    task automatic run_recovery(input int len, output int stat_n, output int fatal_n);
        stat_n  = 0;
        fatal_n = 0;
        rst_req = 1'b1;
        for (int k = 1; k <= len; k++) begin
            tick();
            if (k == 1) rst_req = 1'b0;
            if (rst_stat_o) stat_n++;
            if (fatal_o) fatal_n++;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; rst_req = 1'b0; fatal_clr = 1'b0; hold = 8'd0; settle = 8'd0;
        tick();
        tick();
        n_vec++;
        if (outs !== OutsIdle || retry_cnt_o !== 8'd0 || rst_cnt_o !== 8'd0) begin
            n_err++;
            $display("FAIL reset_values: outs=%b retry=%0d total=%0d, want outs=%b retry=0 total=0",
                     outs, retry_cnt_o, rst_cnt_o, OutsIdle);
        end
        rst_i = 1'b0;
        tick();
        n_vec++;
        if (outs !== OutsIdle) begin
            n_err++;
            $display("FAIL reset_release_idle: outs=%b want %b", outs, OutsIdle);
        end
    endtask

    task automatic test_basic();
        logic [4:0] exp;
        hold = 8'd4; settle = 8'd2;
        rst_req = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 1) rst_req = 1'b0;
            exp = {k <= 15, !(k >= 9 && k <= 12), k == 15, k <= 15, 1'b0};
            n_vec++;
            if (outs !== exp) begin
                n_err++;
                $display("FAIL basic_cycle_%0d: outs=%b want %b", k, outs, exp);
            end
        end
        n_vec++;
        if (retry_cnt_o !== 8'd1) begin
            n_err++;
            $display("FAIL basic_retry: got %0d want 1", retry_cnt_o);
        end
    endtask

    task automatic test_zero_len();
        logic [4:0] exp;
        hold = 8'd0; settle = 8'd0;
        rst_req = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 1) rst_req = 1'b0;
            exp = {k <= 10, k != 9, k == 10, k <= 10, 1'b0};
            n_vec++;
            if (outs !== exp) begin
                n_err++;
                $display("FAIL zero_cycle_%0d: outs=%b want %b", k, outs, exp);
            end
            // Lengths were captured at the ISOLATE->ASSERT edge; later changes must not matter.
            if (k == 9) begin hold = 8'd7; settle = 8'd7; end
        end
        n_vec++;
        if (retry_cnt_o !== 8'd2) begin
            n_err++;
            $display("FAIL zero_retry: got %0d want 2", retry_cnt_o);
        end
    endtask

    task automatic test_escalation();
        do_reset();
        hold = 8'd1; settle = 8'd1;
        rst_req = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (k <= 36) begin
                n_vec++;
                if (rst_stat_o !== ((k % 12) == 11)) begin
                    n_err++;
                    $display("FAIL esc_stat_cycle_%0d: got %b want %b", k, rst_stat_o, (k % 12) == 11);
                end
                if ((k % 12) == 0) begin
                    n_vec++;
                    if (outs !== OutsIdle || retry_cnt_o !== 8'(k / 12)) begin
                        n_err++;
                        $display("FAIL esc_idle_cycle_%0d: outs=%b retry=%0d want outs=%b retry=%0d",
                                 k, outs, retry_cnt_o, OutsIdle, k / 12);
                    end
                end
            end else begin
                n_vec++;
                if (outs !== OutsFatal) begin
                    n_err++;
                    $display("FAIL esc_fatal_cycle_%0d: outs=%b want %b", k, outs, OutsFatal);
                end
            end
        end
        rst_req   = 1'b0;
        fatal_clr = 1'b1;
        tick();
        fatal_clr = 1'b0;
        n_vec++;
        if (outs !== OutsIdle || retry_cnt_o !== 8'd0) begin
            n_err++;
            $display("FAIL esc_fatal_clr: outs=%b retry=%0d want outs=%b retry=0", outs, retry_cnt_o, OutsIdle);
        end
    endtask

    task automatic test_quiet_window();
        int sp, fs;
        do_reset();
        hold = 8'd1; settle = 8'd1;
        run_recovery(12, sp, fs);
        run_recovery(12, sp, fs);
        n_vec++;
        if (retry_cnt_o !== 8'd2) begin
            n_err++;
            $display("FAIL quiet_pre_retry: got %0d want 2", retry_cnt_o);
        end
        for (int j = 1; j <= 256; j++) begin
            tick();
            if (j == 255) begin
                n_vec++;
                if (retry_cnt_o !== 8'd2) begin
                    n_err++;
                    $display("FAIL quiet_255: retry=%0d want 2", retry_cnt_o);
                end
            end
        end
        n_vec++;
        if (retry_cnt_o !== 8'd0) begin
            n_err++;
            $display("FAIL quiet_256: retry=%0d want 0", retry_cnt_o);
        end
        for (int r = 1; r <= 3; r++) begin
            run_recovery(12, sp, fs);
            n_vec++;
            if (sp != 1 || fs != 0 || retry_cnt_o !== 8'(r)) begin
                n_err++;
                $display("FAIL quiet_recovery_%0d: pulses=%0d fatal_cycles=%0d retry=%0d want 1 0 %0d",
                         r, sp, fs, retry_cnt_o, r);
            end
        end
    endtask

    task automatic test_reset_mid();
        int sp, fs, srn_low, stat_at;
        do_reset();
        hold = 8'd4; settle = 8'd2;
        run_recovery(16, sp, fs);
        rst_req = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) rst_req = 1'b0;
        end
        n_vec++;
        if (outs !== 5'b10010 || retry_cnt_o !== 8'd1) begin
            n_err++;
            $display("FAIL mid_in_assert: outs=%b retry=%0d want 10010 1", outs, retry_cnt_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        n_vec++;
        if (outs !== OutsIdle || retry_cnt_o !== 8'd0) begin
            n_err++;
            $display("FAIL mid_reset_values: outs=%b retry=%0d want %b 0", outs, retry_cnt_o, OutsIdle);
        end
        sp = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (rst_stat_o || outs !== OutsIdle) sp++;
        end
        n_vec++;
        if (sp != 0) begin
            n_err++;
            $display("FAIL mid_no_pulse: %0d non-idle cycles after reset, want 0", sp);
        end
        srn_low = 0;
        stat_at = 0;
        rst_req = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 1) rst_req = 1'b0;
            if (!sub_rst_no) srn_low++;
            if (rst_stat_o) stat_at = k;
        end
        n_vec++;
        if (srn_low != 4 || stat_at != 15 || retry_cnt_o !== 8'd1) begin
            n_err++;
            $display("FAIL mid_clean_seq: srn_low=%0d stat_at=%0d retry=%0d want 4 15 1",
                     srn_low, stat_at, retry_cnt_o);
        end
    endtask

    task automatic test_rst_cnt();
        int sp, fs, exp;
        do_reset();
        hold = 8'd0; settle = 8'd0;
        for (int i = 0; i < NumRecov; i++) begin
            if (i != 0 && (i % 3) == 0) begin
                rst_req = 1'b1;
                tick();
                rst_req = 1'b0;
                if (i == 3) begin
                    n_vec++;
                    if (fatal_o !== 1'b1) begin
                        n_err++;
                        $display("FAIL cnt_escalate: fatal=%b want 1", fatal_o);
                    end
                end
                fatal_clr = 1'b1;
                tick();
                fatal_clr = 1'b0;
            end
            run_recovery(11, sp, fs);
            if (i == 0 || i == 253 || i == 254 || i == NumRecov - 1) begin
                exp = CntEn ? ((i + 1 > 255) ? 255 : i + 1) : 0;
                n_vec++;
                if (rst_cnt_o !== 8'(exp) || sp != 1) begin
                    n_err++;
                    $display("FAIL rst_cnt_after_%0d: got %0d pulses=%0d want %0d 1", i + 1, rst_cnt_o, sp, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_escalation();
        test_quiet_window();
        test_reset_mid();
        test_rst_cnt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
